// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types for the ECC checker scheduler.
// FSM states, transaction kinds and syndrome width.
package ecc_pkg;

  localparam int SYND_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ISSUE    = 2'd2,
    WAIT_CHK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_RD    = 2'd0,
    KIND_WR    = 2'd1,
    KIND_SCRUB = 2'd2
  } kind_e;

endpackage

// File: rtl/ecc_rr_arbiter.sv
// ecc_rr_arbiter: 2-way round-robin between read and read-for-write.
// Pointer 0 favours read, 1 favours write; it toggles on every grant.
module ecc_rr_arbiter (
  input  logic clk,
  input  logic reset_n,
  input  logic req_rd,
  input  logic req_wr,
  input  logic advance,
  output logic gnt_rd,
  output logic gnt_wr
);

  logic ptr_q;
  logic ptr_d;

  assign gnt_rd = req_rd & (~req_wr | ~ptr_q);
  assign gnt_wr = req_wr & (~req_rd | ptr_q);

  // flip priority after each granted rd/wr
  always_comb begin
    ptr_d = advance ? ~ptr_q : ptr_q;
  end

  // pointer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ecc_check_scheduler.sv
// ecc_check_scheduler: fetch stripe, issue one Hamming check, report.
// Optional background scrub when ECC_SCRUB_EN is defined.
module ecc_check_scheduler
  import ecc_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 12,
  parameter int TIMEOUT    = 15,
  parameter int ERR_CNT_W  = 16,
  parameter int SCRUB_IDLE = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 rd_disk,
  input  logic                 wr_disk,
  output logic                 rd_ack,
  output logic                 wr_ack,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_rvalid,
  input  logic [DATA_W-1:0]    mem_d0,
  input  logic [DATA_W-1:0]    mem_d1,
  input  logic [DATA_W-1:0]    mem_p,
  output logic                 chk_valid_read,
  output logic                 chk_valid_write,
  output logic [DATA_W-1:0]    chk_enc_old,
  output logic [DATA_W-1:0]    chk_d0,
  output logic [DATA_W-1:0]    chk_d1,
  output logic [DATA_W-1:0]    chk_p,
  output logic [ADDR_W-1:0]    chk_addr,
  input  logic                 chk_done,
  input  logic [SYND_W-1:0]    chk_synd,
  output logic                 done_valid,
  output logic [1:0]           done_kind,
  output logic [SYND_W-1:0]    done_synd,
  output logic                 done_timeout,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic                disk_q, disk_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TMO_W-1:0]    timer_q, timer_d;

  logic                rd_ack_q, rd_ack_d;
  logic                wr_ack_q, wr_ack_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                cvr_q, cvr_d;
  logic                cvw_q, cvw_d;
  logic [DATA_W-1:0]   enc_q, enc_d;
  logic [DATA_W-1:0]   cd0_q, cd0_d;
  logic [DATA_W-1:0]   cd1_q, cd1_d;
  logic [DATA_W-1:0]   cp_q, cp_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;
  logic                dv_q, dv_d;
  logic [1:0]          dkind_q, dkind_d;
  logic [SYND_W-1:0]   dsynd_q, dsynd_d;
  logic                dto_q, dto_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic                gnt_rd, gnt_wr, advance;
  logic                go, go_disk;
  kind_e               go_kind;
  logic [ADDR_W-1:0]   go_addr;

`ifdef ECC_SCRUB_EN
  localparam int IDL_W = $clog2(SCRUB_IDLE + 1);
  logic [IDL_W-1:0]    idle_q, idle_d;
  logic [ADDR_W-1:0]   sptr_q, sptr_d;
  logic                sdisk_q, sdisk_d;
`endif

  assign advance = (state_q == IDLE) & (gnt_rd | gnt_wr);

  ecc_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_rd  (rd_req),
    .req_wr  (wr_req),
    .advance (advance),
    .gnt_rd  (gnt_rd),
    .gnt_wr  (gnt_wr)
  );

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    disk_d      = disk_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    rd_ack_d    = 1'b0;
    wr_ack_d    = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = '0;
    cvr_d       = 1'b0;
    cvw_d       = 1'b0;
    enc_d       = '0;
    cd0_d       = '0;
    cd1_d       = '0;
    cp_d        = '0;
    caddr_d     = '0;
    dv_d        = 1'b0;
    dkind_d     = '0;
    dsynd_d     = '0;
    dto_d       = 1'b0;
    err_d       = err_q;
    go          = gnt_rd | gnt_wr;
    go_kind     = gnt_wr ? KIND_WR : KIND_RD;
    go_addr     = gnt_wr ? wr_addr : rd_addr;
    go_disk     = gnt_wr ? wr_disk : rd_disk;
`ifdef ECC_SCRUB_EN
    idle_d  = idle_q;
    sptr_d  = sptr_q;
    sdisk_d = sdisk_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef ECC_SCRUB_EN
        idle_d = go ? '0 : idle_q + 1'b1;
        if (!go && idle_q == IDL_W'(SCRUB_IDLE - 1)) begin
          go      = 1'b1;
          go_kind = KIND_SCRUB;
          go_addr = sptr_q;
          go_disk = sdisk_q;
          idle_d  = '0;
          sdisk_d = ~sdisk_q;
          if (sdisk_q) sptr_d = sptr_q + 1'b1;
        end
`endif
        if (go) begin
          rd_ack_d    = gnt_rd;
          wr_ack_d    = gnt_wr;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = go_addr;
          kind_d      = go_kind;
          addr_d      = go_addr;
          disk_d      = go_disk;
          timer_d     = '0;
          state_d     = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid) begin
          cvr_d   = (kind_q != KIND_WR);
          cvw_d   = (kind_q == KIND_WR);
          enc_d   = disk_q ? mem_d1 : mem_d0;
          cd0_d   = mem_d0;
          cd1_d   = mem_d1;
          cp_d    = mem_p;
          caddr_d = addr_q;
          timer_d = '0;
          state_d = ISSUE;
        end else if (timer_q == TMO_W'(TIMEOUT - 1)) begin
          dv_d    = 1'b1;
          dto_d   = 1'b1;
          dkind_d = kind_q;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_CHK;
      end
      WAIT_CHK: begin
        if (chk_done) begin
          dv_d    = 1'b1;
          dkind_d = kind_q;
          dsynd_d = chk_synd;
          if (chk_synd != '0 && err_q != '1) err_d = err_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      kind_q      <= KIND_RD;
      disk_q      <= 1'b0;
      addr_q      <= '0;
      timer_q     <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      cvr_q       <= 1'b0;
      cvw_q       <= 1'b0;
      enc_q       <= '0;
      cd0_q       <= '0;
      cd1_q       <= '0;
      cp_q        <= '0;
      caddr_q     <= '0;
      dv_q        <= 1'b0;
      dkind_q     <= '0;
      dsynd_q     <= '0;
      dto_q       <= 1'b0;
      err_q       <= '0;
`ifdef ECC_SCRUB_EN
      idle_q      <= '0;
      sptr_q      <= '0;
      sdisk_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      disk_q      <= disk_d;
      addr_q      <= addr_d;
      timer_q     <= timer_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      cvr_q       <= cvr_d;
      cvw_q       <= cvw_d;
      enc_q       <= enc_d;
      cd0_q       <= cd0_d;
      cd1_q       <= cd1_d;
      cp_q        <= cp_d;
      caddr_q     <= caddr_d;
      dv_q        <= dv_d;
      dkind_q     <= dkind_d;
      dsynd_q     <= dsynd_d;
      dto_q       <= dto_d;
      err_q       <= err_d;
`ifdef ECC_SCRUB_EN
      idle_q      <= idle_d;
      sptr_q      <= sptr_d;
      sdisk_q     <= sdisk_d;
`endif
    end
  end

  assign rd_ack          = rd_ack_q;
  assign wr_ack          = wr_ack_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign mem_addr        = mem_addr_q;
  assign chk_valid_read  = cvr_q;
  assign chk_valid_write = cvw_q;
  assign chk_enc_old     = enc_q;
  assign chk_d0          = cd0_q;
  assign chk_d1          = cd1_q;
  assign chk_p           = cp_q;
  assign chk_addr        = caddr_q;
  assign done_valid      = dv_q;
  assign done_kind       = dkind_q;
  assign done_synd       = dsynd_q;
  assign done_timeout    = dto_q;
  assign err_cnt         = err_q;

endmodule

// File: tb/tb_ecc_check_scheduler.sv
// tb_ecc_check_scheduler: directed checks of the ECC check scheduler.
// Memory and checker responses are driven by hand each step.
module tb_ecc_check_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req, wr_req;
  logic [7:0]  rd_addr, wr_addr;
  logic        rd_disk, wr_disk;
  logic        rd_ack, wr_ack;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic        mem_rvalid;
  logic [11:0] mem_d0, mem_d1, mem_p;
  logic        chk_valid_read, chk_valid_write;
  logic [11:0] chk_enc_old, chk_d0, chk_d1, chk_p;
  logic [7:0]  chk_addr;
  logic        chk_done;
  logic [3:0]  chk_synd;
  logic        done_valid;
  logic [1:0]  done_kind;
  logic [3:0]  done_synd;
  logic        done_timeout;
  logic [15:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ecc_check_scheduler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rd_req          (rd_req),
    .wr_req          (wr_req),
    .rd_addr         (rd_addr),
    .wr_addr         (wr_addr),
    .rd_disk         (rd_disk),
    .wr_disk         (wr_disk),
    .rd_ack          (rd_ack),
    .wr_ack          (wr_ack),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rvalid      (mem_rvalid),
    .mem_d0          (mem_d0),
    .mem_d1          (mem_d1),
    .mem_p           (mem_p),
    .chk_valid_read  (chk_valid_read),
    .chk_valid_write (chk_valid_write),
    .chk_enc_old     (chk_enc_old),
    .chk_d0          (chk_d0),
    .chk_d1          (chk_d1),
    .chk_p           (chk_p),
    .chk_addr        (chk_addr),
    .chk_done        (chk_done),
    .chk_synd        (chk_synd),
    .done_valid      (done_valid),
    .done_kind       (done_kind),
    .done_synd       (done_synd),
    .done_timeout    (done_timeout),
    .err_cnt         (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rd_req = 0; wr_req = 0; rd_addr = 0; wr_addr = 0;
    rd_disk = 0; wr_disk = 0; mem_rvalid = 0;
    mem_d0 = 0; mem_d1 = 0; mem_p = 0;
    chk_done = 0; chk_synd = 0;
    repeat (3) tick();
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_chk_valid", {chk_valid_read, chk_valid_write}, 0);
    reset_n = 1'b1;
    tick();

    // read of D1 at 0x12, clean syndrome
    rd_req = 1; rd_addr = 8'h12; rd_disk = 1;
    tick();
    chk("t1_rd_ack", rd_ack, 1);
    chk("t1_mem_rd_en", mem_rd_en, 1);
    chk("t1_mem_addr", mem_addr, 8'h12);
    rd_req = 0;
    mem_rvalid = 1; mem_d0 = 12'h111; mem_d1 = 12'hABC; mem_p = 12'h222;
    tick();
    chk("t1_cvr", chk_valid_read, 1);
    chk("t1_cvw", chk_valid_write, 0);
    chk("t1_enc_old", chk_enc_old, 12'hABC);
    chk("t1_chk_addr", chk_addr, 8'h12);
    chk("t1_chk_p", chk_p, 12'h222);
    chk("t1_ack_pulse", {rd_ack, mem_rd_en}, 0);
    mem_rvalid = 0;
    tick();
    chk("t1_cvr_pulse", chk_valid_read, 0);
    chk("t1_enc_clear", chk_enc_old, 0);
    chk_done = 1; chk_synd = 0;
    tick();
    chk("t1_done_valid", done_valid, 1);
    chk("t1_done_kind", done_kind, 0);
    chk("t1_done_synd", done_synd, 0);
    chk("t1_err_cnt", err_cnt, 0);
    chk_done = 0;

    // simultaneous requests after reset: read first
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    rd_req = 1; rd_addr = 8'h20; rd_disk = 0;
    wr_req = 1; wr_addr = 8'h30; wr_disk = 1;
    tick();
    chk("t2_rd_ack", rd_ack, 1);
    chk("t2_wr_ack0", wr_ack, 0);
    chk("t2_mem_addr", mem_addr, 8'h20);
    rd_req = 0;
    mem_rvalid = 1; mem_d0 = 12'h0F0; mem_d1 = 12'h00F; mem_p = 12'h555;
    tick();
    chk("t2_enc_old", chk_enc_old, 12'h0F0);
    chk("t2_wr_busy", wr_ack, 0);
    mem_rvalid = 0;
    tick();
    chk_done = 1; chk_synd = 0;
    tick();
    chk("t2_done_valid", done_valid, 1);
    chk("t2_wr_wait", wr_ack, 0);
    chk_done = 0;
    tick();
    chk("t2_wr_ack", wr_ack, 1);
    chk("t2_wr_addr", mem_addr, 8'h30);
    wr_req = 0;

    // read-for-write with single-bit-pattern syndrome 0101
    mem_rvalid = 1; mem_d0 = 12'h111; mem_d1 = 12'h5A5; mem_p = 12'h333;
    tick();
    chk("t3_cvw", chk_valid_write, 1);
    chk("t3_cvr", chk_valid_read, 0);
    chk("t3_enc_old", chk_enc_old, 12'h5A5);
    chk("t3_chk_addr", chk_addr, 8'h30);
    mem_rvalid = 0;
    tick();
    chk_done = 1; chk_synd = 4'b0101;
    tick();
    chk("t3_done_valid", done_valid, 1);
    chk("t3_done_kind", done_kind, 1);
    chk("t3_done_synd", done_synd, 5);
    chk("t3_err_cnt", err_cnt, 1);
    chk_done = 0; chk_synd = 0;

    // memory timeout
    rd_req = 1; rd_addr = 8'h40; rd_disk = 0;
    tick();
    chk("t4_rd_ack", rd_ack, 1);
    rd_req = 0;
    repeat (14) tick();
    chk("t4_no_done_early", done_valid, 0);
    tick();
    chk("t4_done_valid", done_valid, 1);
    chk("t4_timeout", done_timeout, 1);
    chk("t4_done_synd", done_synd, 0);
    chk("t4_done_kind", done_kind, 0);
    mem_rvalid = 1;
    tick();
    chk("t4_stray_rvalid", {chk_valid_read, chk_valid_write}, 0);
    mem_rvalid = 0;
    wr_req = 1; wr_addr = 8'h55; wr_disk = 0;
    tick();
    chk("t4_wr_ack", wr_ack, 1);
    chk("t4_wr_addr", mem_addr, 8'h55);
    wr_req = 0;
    mem_rvalid = 1; mem_d0 = 12'h123; mem_d1 = 12'h456;
    tick();
    chk("t4_enc_old", chk_enc_old, 12'h123);
    chk("t4_cvw", chk_valid_write, 1);
    mem_rvalid = 0;
    tick();
    chk_done = 1; chk_synd = 0;
    tick();
    chk("t4_next_done", done_valid, 1);
    chk("t4_next_to", done_timeout, 0);
    chk("t4_err_hold", err_cnt, 1);
    chk_done = 0;

    // reset during WAIT_CHK
    rd_req = 1; rd_addr = 8'h66; rd_disk = 1;
    tick();
    rd_req = 0;
    mem_rvalid = 1; mem_d1 = 12'h777;
    tick();
    mem_rvalid = 0;
    tick();
    chk_done = 1; chk_synd = 4'h3;
    reset_n = 0;
    #1;
    chk("t5_rst_done", done_valid, 0);
    chk("t5_rst_err", err_cnt, 0);
    chk("t5_rst_outs", {rd_ack, wr_ack, mem_rd_en, chk_valid_read}, 0);
    tick();
    chk("t5_no_done", done_valid, 0);
    chk_done = 0; chk_synd = 0;
    reset_n = 1;
    tick();
    rd_req = 1; rd_addr = 8'h77; rd_disk = 0;
    tick();
    chk("t5_rd_ack", rd_ack, 1);
    chk("t5_mem_addr", mem_addr, 8'h77);
    rd_req = 0;
    mem_rvalid = 1; mem_d0 = 12'h0AA;
    tick();
    chk("t5_enc_old", chk_enc_old, 12'h0AA);
    mem_rvalid = 0;
    tick();
    chk_done = 1; chk_synd = 4'h1;
    tick();
    chk("t5_done_synd", done_synd, 1);
    chk("t5_err_cnt", err_cnt, 1);
    chk_done = 0; chk_synd = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
